// File: rtl/matvec_column_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matvec_column_engine_pkg                                        |
// | Purpose  : Shared types, constants and helpers for the column engine.      |
// |            Provides the FSM state encoding, the default fractional bit     |
// |            count, a log2 helper and the fixed-point shift/saturate used     |
// |            to turn a wide accumulator back into an element-width value.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package matvec_column_engine_pkg;

  localparam int FRAC_DEFAULT = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Ceiling log2; used to derive the address width from the column count.
  function automatic int log2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

  // Arithmetic right shift (floor) followed by clamping to a signed range of
  // 'width' bits. Operates on a 64-bit container so one function serves any
  // accumulator width up to 63 bits; callers keep only the low 'width' bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int               frac,
                                                   input int               width);
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted = acc >>> frac;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (width - 1));
    if (shifted > max_v)      return max_v;
    else if (shifted < min_v) return min_v;
    else                      return shifted;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_column_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matvec_column_engine_if                                         |
// | Purpose  : Request/RAM/result bundle between the column engine and its    |
// |            environment.                                                   |
// | Signals  : start      request, sampled only while the engine is idle      |
// |            vectorIn   input vector x, element k at [k*BITWIDTH +:]        |
// |            addressOut weight RAM read address                             |
// |            rowIn      RAM read data (one column), lane r at [r*BITWIDTH +:]|
// |            busy       high from accepted start until done                 |
// |            done       one-cycle result-valid pulse                        |
// |            result     saturated W*x, lane r packed like rowIn             |
// | Modports : master = requester / RAM side, slave = engine side             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface matvec_column_engine_if
  import matvec_column_engine_pkg::*;
#(
  parameter int NROW     = 16,
  parameter int NCOL     = 16,
  parameter int BITWIDTH = 18
) ();

  localparam int ADDR_BITWIDTH = log2(NCOL);

  logic                       start;
  logic [BITWIDTH*NCOL-1:0]   vectorIn;
  logic [ADDR_BITWIDTH-1:0]   addressOut;
  logic [BITWIDTH*NROW-1:0]   rowIn;
  logic                       busy;
  logic                       done;
  logic [BITWIDTH*NROW-1:0]   result;

  modport master (
    output start, vectorIn, rowIn,
    input  addressOut, busy, done, result
  );

  modport slave (
    input  start, vectorIn, rowIn,
    output addressOut, busy, done, result
  );

endinterface
`default_nettype wire

// File: rtl/matvec_column_engine_mac_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matvec_column_engine_mac_lane                                   |
// | Purpose  : One signed multiply-accumulate lane with synchronous clear and |
// |            a combinational shifted/saturated view of the accumulator.     |
// | Ports    : clock, reset  clock and synchronous active-high reset          |
// |            clear         zero the accumulator (start of a new run)        |
// |            enable        add weight*x_elem this cycle                     |
// |            weight,x_elem signed element-width operands                    |
// |            sat_out       sat(acc >>> FRAC), element width                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module matvec_column_engine_mac_lane
  import matvec_column_engine_pkg::*;
#(
  parameter int BITWIDTH     = 18,
  parameter int FRAC         = FRAC_DEFAULT,
  parameter int ACC_BITWIDTH = 40
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  input  logic signed [BITWIDTH-1:0] weight,
  input  logic signed [BITWIDTH-1:0] x_elem,
  output logic signed [BITWIDTH-1:0] sat_out
);

  localparam int PROD_BITWIDTH = 2 * BITWIDTH;

  logic signed [PROD_BITWIDTH-1:0] w_product;
  logic signed [ACC_BITWIDTH-1:0]  r_acc;

  // Full-precision product; both operands signed so the multiply is signed.
  assign w_product = weight * x_elem;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_acc <= '0;
    end else if (enable) begin
      // Signed size cast sign-extends the product into the accumulator.
      r_acc <= r_acc + ACC_BITWIDTH'(w_product);
    end
  end

  assign sat_out = BITWIDTH'(sat_shift(64'(r_acc), FRAC, BITWIDTH));

endmodule
`default_nettype wire

// File: rtl/matvec_column_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : matvec_column_engine                                            |
// | Purpose  : Streams NCOL weight columns from a registered-output RAM, one  |
// |            address per cycle, multiplying each column by the matching     |
// |            element of a latched vector and accumulating NROW dot products |
// |            in parallel. Emits a saturated fixed-point result with a       |
// |            start/busy/done handshake.                                     |
// | Ports    : clock  single rising-edge clock                                |
// |            reset  synchronous active-high reset                           |
// |            bus    matvec_column_engine_if.slave (start, vectorIn,         |
// |                   addressOut, rowIn, busy, done, result)                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module matvec_column_engine
  import matvec_column_engine_pkg::*;
#(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int BITWIDTH      = 18,
  parameter int FRAC          = FRAC_DEFAULT,
  parameter int ADDR_BITWIDTH = log2(NCOL),
  parameter int ACC_BITWIDTH  = 2 * BITWIDTH + ADDR_BITWIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  matvec_column_engine_if.slave bus
);

  localparam logic [ADDR_BITWIDTH-1:0] C_LAST_ADDR   = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic [ADDR_BITWIDTH-1:0] C_PENULT_ADDR = ADDR_BITWIDTH'(NCOL - 2);

  state_t                      r_state;
  state_t                      w_state_next;
  logic                        w_accept;
  logic                        w_finish;
  logic                        w_addr_inc;

  logic [ADDR_BITWIDTH-1:0]    r_addr;
  logic                        r_issue;      // a read address is on addressOut this cycle
  logic                        r_col_valid;  // rowIn holds column r_col_idx this cycle
  logic [ADDR_BITWIDTH-1:0]    r_col_idx;
  logic [BITWIDTH*NCOL-1:0]    r_x;
  logic [BITWIDTH*NROW-1:0]    r_result;
  logic                        r_done;

  logic signed [BITWIDTH-1:0]  w_x_elem;
  logic [BITWIDTH*NROW-1:0]    w_lane_sat;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_addr_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // The increment onto the last address is the final RUN edge.
        w_addr_inc = 1'b1;
        if (r_addr == C_PENULT_ADDR) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave once the last column is being accumulated this cycle.
        if (r_col_valid && (r_col_idx == C_LAST_ADDR)) w_state_next = ST_FINISH;
      end
      ST_FINISH: begin
        w_finish     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_issue     <= 1'b0;
      r_col_valid <= 1'b0;
      r_col_idx   <= '0;
      r_x         <= '0;
      r_result    <= '0;
      r_done      <= 1'b0;
    end else begin
      // RAM data lags the address by one cycle; delay valid/index to match.
      r_col_valid <= r_issue;
      r_col_idx   <= r_addr;
      r_done      <= w_finish;

      if (w_accept) begin
        r_x     <= bus.vectorIn;
        r_addr  <= '0;
        r_issue <= 1'b1;
      end else if (r_state == ST_DRAIN) begin
        // First DRAIN cycle still presents the last address.
        r_issue <= 1'b0;
      end

      if (w_addr_inc) r_addr <= r_addr + ADDR_BITWIDTH'(1);

      if (w_finish) begin
        r_result <= w_lane_sat;
        r_addr   <= '0;
      end
    end
  end

  assign w_x_elem = r_x[r_col_idx*BITWIDTH +: BITWIDTH];

  generate
    for (genvar g = 0; g < NROW; g++) begin : g_lanes
      matvec_column_engine_mac_lane #(
        .BITWIDTH     (BITWIDTH),
        .FRAC         (FRAC),
        .ACC_BITWIDTH (ACC_BITWIDTH)
      ) u_lane (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_accept),
        .enable  (r_col_valid),
        .weight  (bus.rowIn[g*BITWIDTH +: BITWIDTH]),
        .x_elem  (w_x_elem),
        .sat_out (w_lane_sat[g*BITWIDTH +: BITWIDTH])
      );
    end
  endgenerate

  assign bus.addressOut = r_addr;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = r_done;
  assign bus.result     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_matvec_column_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_matvec_column_engine                                         |
// | Purpose  : Self-checking bench for matvec_column_engine: RAM model with   |
// |            one-cycle read latency, scoreboard of expected results fed by  |
// |            the stimulus, and a monitor that checks every done pulse.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_matvec_column_engine;

  localparam int NROW = 16;
  localparam int NCOL = 16;
  localparam int BW   = 18;
  localparam int FRAC = 11;
  localparam int RW   = BW * NROW;

  typedef struct {
    logic [RW-1:0] res;
    longint        due;
  } exp_t;

  logic   clock = 1'b0;
  logic   reset;
  longint edge_cnt = 0;
  int     checks = 0;
  int     passed = 0;

  int     w_mem [NCOL][NROW];   // w_mem[column][row]
  int     x_vec [NCOL];
  exp_t   sb [$];

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt++;

  matvec_column_engine_if #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) bus ();

  matvec_column_engine #(
    .NROW     (NROW),
    .NCOL     (NCOL),
    .BITWIDTH (BW),
    .FRAC     (FRAC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Weight RAM: registered read, data for the sampled address next cycle.
  always @(posedge clock) begin
    for (int r = 0; r < NROW; r++)
      bus.rowIn[r*BW +: BW] <= BW'(w_mem[bus.addressOut][r]);
  end

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [BW*NCOL-1:0] pack_x();
    logic [BW*NCOL-1:0] v;
    for (int k = 0; k < NCOL; k++) v[k*BW +: BW] = BW'(x_vec[k]);
    return v;
  endfunction

  // Reference: y[r] = clamp(floor(sum_k W[r][k]*x[k] / 2^FRAC)).
  function automatic logic [RW-1:0] model();
    logic [RW-1:0] v;
    longint s, q, hi, lo, scale;
    scale = longint'(1) << FRAC;
    hi    = (longint'(1) << (BW - 1)) - 1;
    lo    = -(longint'(1) << (BW - 1));
    for (int r = 0; r < NROW; r++) begin
      s = 0;
      for (int k = 0; k < NCOL; k++) s += longint'(w_mem[k][r]) * longint'(x_vec[k]);
      q = s / scale;
      if (s < 0 && (s % scale) != 0) q -= 1;
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      v[r*BW +: BW] = BW'(q);
    end
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", RW'(bus.done), RW'(0));
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("done_latency", RW'(edge_cnt), RW'(e.due));
        chk("busy_low_with_done", RW'(bus.busy), RW'(0));
      end
    end
  end

  task automatic push_expect(output logic [RW-1:0] res);
    res = model();
    sb.push_back('{res: res, due: edge_cnt + NCOL + 3});
  endtask

  task automatic issue(output logic [RW-1:0] res);
    @(negedge clock);
    bus.vectorIn = pack_x();
    bus.start    = 1'b1;
    push_expect(res);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit check_pulse, input logic [RW-1:0] held);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * NCOL && !seen; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", RW'(bus.done), RW'(1));
    else if (check_pulse) begin
      @(negedge clock);
      chk("done_pulse_width", RW'(bus.done), RW'(0));
      chk("result_held", bus.result, held);
    end
  endtask

  task automatic fill(input int w, input int x);
    for (int k = 0; k < NCOL; k++) begin
      x_vec[k] = x;
      for (int r = 0; r < NROW; r++) w_mem[k][r] = w;
    end
  endtask

  task automatic load_identity();
    for (int k = 0; k < NCOL; k++) begin
      x_vec[k] = k * 2048;
      for (int r = 0; r < NROW; r++) w_mem[k][r] = (r == k) ? 2048 : 0;
    end
  endtask

  task automatic run_identity_with_addr();
    logic [RW-1:0] res;
    @(negedge clock);
    bus.vectorIn = pack_x();
    bus.start    = 1'b1;
    push_expect(res);
    for (int k = 0; k < NCOL; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      chk($sformatf("address_%0d", k), RW'(bus.addressOut), RW'(k));
    end
    wait_done(1'b1, res);
  endtask

  initial begin
    logic [RW-1:0] res;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.vectorIn = '0;
    fill(0, 0);
    repeat (3) @(negedge clock);
    chk("reset_busy", RW'(bus.busy), RW'(0));
    chk("reset_done", RW'(bus.done), RW'(0));
    chk("reset_result", bus.result, RW'(0));
    chk("reset_address", RW'(bus.addressOut), RW'(0));
    reset = 1'b0;

    // Identity: address sequence, latency and r*2048 per lane.
    load_identity();
    run_identity_with_addr();

    // Saturation both directions.
    fill(8192, 131071);
    issue(res); wait_done(1'b1, res);
    fill(8192, -131072);
    issue(res); wait_done(1'b1, res);

    // Floor behaviour of the fractional shift.
    fill(1, 1);
    issue(res); wait_done(1'b1, res);
    fill(1, -1);
    issue(res); wait_done(1'b1, res);

    // Randomized runs, alternating small and full-range operands.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < NCOL; k++) begin
        x_vec[k] = (t % 2 == 0) ? int'($urandom_range(0, 8191)) - 4096
                                : int'($urandom_range(0, 262143)) - 131072;
        for (int r = 0; r < NROW; r++)
          w_mem[k][r] = (t % 2 == 0) ? int'($urandom_range(0, 8191)) - 4096
                                     : int'($urandom_range(0, 262143)) - 131072;
      end
      issue(res); wait_done(1'b1, res);
    end

    // Start held through RUN with vectorIn changing: one done, original x.
    for (int k = 0; k < NCOL; k++) x_vec[k] = int'($urandom_range(0, 8191)) - 4096;
    @(negedge clock);
    bus.vectorIn = pack_x();
    bus.start    = 1'b1;
    push_expect(res);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 3)
        for (int k = 0; k < NCOL; k++) bus.vectorIn[k*BW +: BW] = BW'($urandom);
    end
    bus.start = 1'b0;
    wait_done(1'b0, res);

    // Back-to-back: start in the done cycle.
    for (int k = 0; k < NCOL; k++) x_vec[k] = int'($urandom_range(0, 8191)) - 4096;
    bus.vectorIn = pack_x();
    bus.start    = 1'b1;
    push_expect(res);
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(1'b1, res);

    // Reset sampled at E5 of a run: abort with no done.
    load_identity();
    issue(res);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", RW'(bus.busy), RW'(0));
    chk("abort_done", RW'(bus.done), RW'(0));
    chk("abort_result", bus.result, RW'(0));
    chk("abort_address", RW'(bus.addressOut), RW'(0));
    repeat (3 * NCOL) @(negedge clock);

    // Recovery after the abort.
    run_identity_with_addr();

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", RW'(sb.size()), RW'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matvec_column_engine.md
Name: matvec_column_engine

Overview:
- Downstream consumer of the weight RAM.
- Streams the NCOL stored weight columns (each an NROW-wide packed vector) out of the RAM one address per cycle, and multiplies each column by the matching element of a latched input vector.
- Accumulates NROW dot products in parallel and emits a saturated fixed-point result vector with a start/done handshake.
- Forms the core W·x step of each RNN gate.

Parameters:
- NROW, 16, rows per column word; number of parallel MAC lanes.
- NCOL, 16, columns (RAM depth); power of two, ≥2.
- BITWIDTH, 18, signed two's-complement element width.
- FRAC, 11, fractional bits (Q6.11 by default; 1.0 = 2048).
- ADDR_BITWIDTH, log2(NCOL), address width (derived).
- ACC_BITWIDTH, 2*BITWIDTH+ADDR_BITWIDTH, accumulator width (derived; cannot overflow).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- vectorIn  in  BITWIDTH*NCOL  input vector x; element k at bits [k*BITWIDTH +: BITWIDTH]; latched on accepted start.
- addressOut  out  ADDR_BITWIDTH  read address to the weight RAM.
- rowIn  in  BITWIDTH*NROW  RAM read data, 1-cycle registered latency; lane r at [r*BITWIDTH +: BITWIDTH].
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse; result valid.
- result  out  BITWIDTH*NROW  saturated y = W·x, lane r packed as rowIn; held until next done or reset.

Behaviour:
- Reset, synchronous on the clock edge with reset=1: state IDLE; addressOut=0, busy=0, done=0, result=0; accumulators, counters and latched x cleared. Applies in any state, including mid-computation; an aborted run produces no done.
- FSM states:
  - IDLE: start=1 at edge E0 latches vectorIn, clears accumulators, sets addr counter to 0, goes to RUN.
  - RUN: after edge Ek (k=0..NCOL-1), addressOut=k. Counter holds at NCOL-1 and never wraps. After E(NCOL-1), goes to DRAIN.
  - DRAIN: waits for the last column to return.
  - FINISH: writes result and pulses done.
- Data timing:
  - rowIn carries column k after E(k+1).
  - At E(k+2), acc[r] += rowIn[r]*x[k] for k=0..NCOL-1. A one-cycle-delayed valid/index pipe selects x[k].
  - Last accumulate at E(NCOL+1).
  - At E(NCOL+2): result[r] = sat(acc[r] >>> FRAC), done=1, busy=0, state IDLE.
  - done clears at E(NCOL+3).
  - Latency start→done: NCOL+2 edges (18 for defaults).
- Arithmetic:
  - Full-precision signed product, 2*BITWIDTH bits, sign-extended into ACC_BITWIDTH.
  - Arithmetic right shift by FRAC, i.e. floor (truncation toward −inf).
  - Saturate to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1].
- start while busy: ignored. start in the done cycle (state already IDLE): accepted (back-to-back).
- vectorIn changes after acceptance have no effect.
- addressOut holds NCOL-1 through DRAIN/FINISH and returns to 0 in IDLE.
- Precondition: the RAM is not written while busy, since RAM writes suppress reads. Results under violation are unspecified; the bench does not check them.

Decomposition:
- Shared package holds:
  - log2 function.
  - FRAC default.
  - fixed-point saturate function (ACC→BITWIDTH).
  - FSM state encoding constants (IDLE, RUN, DRAIN, FINISH).
- Natural sub-module: mac_lane, one signed MAC with clear/enable and saturating output, instantiated NROW times via generate.

Test Plan:
- Identity:
  - Stimulus: W[r][k]=2048 if r==k else 0; x[k]=k*2048; start pulse.
  - Response: addressOut 0..15 on consecutive cycles; done exactly 18 edges after start; result[r]=r*2048; busy low with done.
- Saturation:
  - Stimulus: all W=8192 (4.0), all x=131071.
  - Response: every lane =131071.
  - Repeat with x=−131072: every lane =−131072.
- Truncation/floor:
  - Stimulus: all W=1, all x=1.
  - Response: acc=16, result=0.
  - With x=−1: acc=−16, result=−1 (0x3FFFF).
- Handshake:
  - Stimulus: start held high during RUN; new vectorIn mid-run.
  - Response: single done, result from the originally latched x.
  - Stimulus: start asserted in the done cycle.
  - Response: second run accepted; second done 18 edges after that edge.
- Reset mid-operation:
  - Stimulus: reset at E5 of a run.
  - Response: next cycle busy=0, done=0, result=0, addressOut=0; no done follows; a subsequent run yields correct identity results.
